// File: rtl/pong_pkg.sv
// Shared types and geometry for the Pong game sequencer.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SERVE,
    PLAY,
    SCORED,
    GAME_OVER
  } gameState_t;

  localparam int unsigned SCREEN_W     = 640;
  localparam int unsigned SCREEN_H     = 480;
  localparam int unsigned PADDLE_HALF  = 40;
  localparam int unsigned LEFT_FACE    = 26;
  localparam int unsigned RIGHT_FACE   = 614;
  localparam int unsigned BALL_HALF    = 2;
  localparam int unsigned SPEED        = 2;
  localparam int unsigned SERVE_FRAMES = 60;
  localparam int unsigned WIN_SCORE    = 7;

  localparam logic [9:0] CENTER_X = 10'(SCREEN_W / 2);
  localparam logic [9:0] CENTER_Y = 10'(SCREEN_H / 2);

  // Direction encodings for dx / dy.
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;

endpackage

// File: rtl/pong_ball_step.sv
// One frame of ball motion: wall bounce on Y, paddle bounce or edge miss on X.
module pong_ball_step
  import pong_pkg::*;
(
  input  logic [9:0] ballX,
  input  logic [9:0] ballY,
  input  logic       dx,
  input  logic       dy,
  input  logic [9:0] leftPaddleY,
  input  logic [9:0] rightPaddleY,
  output logic [9:0] nextX,
  output logic [9:0] nextY,
  output logic       nextDx,
  output logic       nextDy,
  output logic       missLeft,
  output logic       missRight
);

  localparam logic [10:0] BH        = 11'(BALL_HALF);
  localparam logic [10:0] SP        = 11'(SPEED);
  localparam logic [10:0] LF        = 11'(LEFT_FACE);
  localparam logic [10:0] RF        = 11'(RIGHT_FACE);
  localparam logic [10:0] REACH     = 11'(PADDLE_HALF + BALL_HALF);
  localparam logic [10:0] TOP_LIM   = 11'(BALL_HALF + SPEED);
  localparam logic [10:0] BOT_LIM   = 11'(SCREEN_H - 1 - BALL_HALF - SPEED);
  localparam logic [10:0] RIGHT_LIM = 11'(SCREEN_W - 1 - BALL_HALF - SPEED);
  localparam logic [9:0]  TOP_REST  = 10'(BALL_HALF);
  localparam logic [9:0]  BOT_REST  = 10'(SCREEN_H - 1 - BALL_HALF);
  localparam logic [9:0]  LEFT_REST = 10'(LEFT_FACE + BALL_HALF + 1);
  localparam logic [9:0]  RIGHT_REST = 10'(RIGHT_FACE - BALL_HALF - 1);
  localparam logic [9:0]  STEP      = 10'(SPEED);

  logic [10:0] x, y, lp, rp;
  logic        leftHit, rightHit;

  assign x  = {1'b0, ballX};
  assign y  = {1'b0, ballY};
  assign lp = {1'b0, leftPaddleY};
  assign rp = {1'b0, rightPaddleY};

  // |y - paddle| <= REACH, written as two additions so nothing goes negative.
  assign leftHit  = (dx == DIR_LEFT) && (x > LF + BH) && (x <= LF + BH + SP) &&
                    (y <= lp + REACH) && (lp <= y + REACH);
  assign rightHit = (dx == DIR_RIGHT) && (x + BH < RF) && (x + BH + SP >= RF) &&
                    (y <= rp + REACH) && (rp <= y + REACH);

  always_comb begin
    nextY  = ballY;
    nextDy = dy;
    if (dy == DIR_UP) begin
      if (y <= TOP_LIM) begin
        nextY  = TOP_REST;
        nextDy = DIR_DOWN;
      end else begin
        nextY = ballY - STEP;
      end
    end else begin
      if (y >= BOT_LIM) begin
        nextY  = BOT_REST;
        nextDy = DIR_UP;
      end else begin
        nextY = ballY + STEP;
      end
    end
  end

  always_comb begin
    nextX     = ballX;
    nextDx    = dx;
    missLeft  = 1'b0;
    missRight = 1'b0;
    if (leftHit) begin
      nextX  = LEFT_REST;
      nextDx = DIR_RIGHT;
    end else if (rightHit) begin
      nextX  = RIGHT_REST;
      nextDx = DIR_LEFT;
    end else if (dx == DIR_LEFT && x <= TOP_LIM) begin
      missLeft = 1'b1;
    end else if (dx == DIR_RIGHT && x >= RIGHT_LIM) begin
      missRight = 1'b1;
    end else if (dx == DIR_LEFT) begin
      nextX = ballX - STEP;
    end else begin
      nextX = ballX + STEP;
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve delay, per-frame ball motion, scoring and game-over.
module pong_game_ctrl
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [9:0] leftPaddleY,
  input  logic [9:0] rightPaddleY,
  output logic [9:0] ballX,
  output logic [9:0] ballY,
  output logic [3:0] leftScore,
  output logic [3:0] rightScore,
  output logic       game_over,
  output logic       serving
);

  gameState_t state, stateNext;
  logic [5:0] serveCnt, serveCntNext;
  logic [9:0] ballXNext, ballYNext;
  logic [3:0] leftScoreNext, rightScoreNext, winnerScore;
  logic       dx, dy, dxNext, dyNext;
  logic       serveDy, serveDyNext;
  logic       scorerLeft, scorerLeftNext;

  logic [9:0] stepX, stepY;
  logic       stepDx, stepDy, missLeft, missRight;

  pong_ball_step u_step (
    .ballX       (ballX),
    .ballY       (ballY),
    .dx          (dx),
    .dy          (dy),
    .leftPaddleY (leftPaddleY),
    .rightPaddleY(rightPaddleY),
    .nextX       (stepX),
    .nextY       (stepY),
    .nextDx      (stepDx),
    .nextDy      (stepDy),
    .missLeft    (missLeft),
    .missRight   (missRight)
  );

  assign winnerScore = (scorerLeft ? leftScore : rightScore) + 4'd1;

  always_comb begin
    stateNext      = state;
    serveCntNext   = serveCnt;
    ballXNext      = ballX;
    ballYNext      = ballY;
    dxNext         = dx;
    dyNext         = dy;
    serveDyNext    = serveDy;
    scorerLeftNext = scorerLeft;
    leftScoreNext  = leftScore;
    rightScoreNext = rightScore;
    case (state)
      IDLE, GAME_OVER: begin
        if (start) begin
          stateNext      = SERVE;
          serveCntNext   = '0;
          leftScoreNext  = '0;
          rightScoreNext = '0;
          ballXNext      = CENTER_X;
          ballYNext      = CENTER_Y;
        end
      end
      SERVE: begin
        ballXNext = CENTER_X;
        ballYNext = CENTER_Y;
        if (frame_tick) begin
          if (serveCnt == 6'(SERVE_FRAMES - 1)) begin
            stateNext    = PLAY;
            serveCntNext = '0;
          end else begin
            serveCntNext = serveCnt + 6'd1;
          end
        end
      end
      PLAY: begin
        if (frame_tick) begin
          ballYNext = stepY;
          dyNext    = stepDy;
          if (missLeft || missRight) begin
            stateNext      = SCORED;
            scorerLeftNext = missRight;
          end else begin
            ballXNext = stepX;
            dxNext    = stepDx;
          end
        end
      end
      SCORED: begin
        if (scorerLeft) leftScoreNext = winnerScore;
        else            rightScoreNext = winnerScore;
        ballXNext    = CENTER_X;
        ballYNext    = CENTER_Y;
        // Serve heads toward whoever just conceded.
        dxNext       = scorerLeft ? DIR_RIGHT : DIR_LEFT;
        dyNext       = ~serveDy;
        serveDyNext  = ~serveDy;
        serveCntNext = '0;
        stateNext    = (winnerScore == 4'(WIN_SCORE)) ? GAME_OVER : SERVE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      serveCnt   <= '0;
      ballX      <= CENTER_X;
      ballY      <= CENTER_Y;
      dx         <= DIR_RIGHT;
      dy         <= DIR_UP;
      serveDy    <= DIR_UP;
      scorerLeft <= 1'b0;
      leftScore  <= '0;
      rightScore <= '0;
      game_over  <= 1'b0;
      serving    <= 1'b0;
    end else begin
      state      <= stateNext;
      serveCnt   <= serveCntNext;
      ballX      <= ballXNext;
      ballY      <= ballYNext;
      dx         <= dxNext;
      dy         <= dyNext;
      serveDy    <= serveDyNext;
      scorerLeft <= scorerLeftNext;
      leftScore  <= leftScoreNext;
      rightScore <= rightScoreNext;
      game_over  <= (stateNext == GAME_OVER);
      serving    <= (stateNext == SERVE);
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: hand-traced ball trajectories through full games.
module tb_pong_game_ctrl;

  localparam int W = 30;
  localparam int WATCHDOG_CYCLES = 20000;

  logic       clk;
  logic       reset;
  logic       frame_tick;
  logic       start;
  logic [9:0] leftPaddleY;
  logic [9:0] rightPaddleY;
  logic [9:0] ballX;
  logic [9:0] ballY;
  logic [3:0] leftScore;
  logic [3:0] rightScore;
  logic       game_over;
  logic       serving;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           tests_run;
  int           tests_failed;
  logic         done;

  pong_game_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .start       (start),
    .leftPaddleY (leftPaddleY),
    .rightPaddleY(rightPaddleY),
    .ballX       (ballX),
    .ballY       (ballY),
    .leftScore   (leftScore),
    .rightScore  (rightScore),
    .game_over   (game_over),
    .serving     (serving)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: all stimulus changes 1 time unit after a rising edge
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic expect_out(input string nm, input int x, input int y, input int ls,
                            input int rs, input int go, input int sv);
    exp_q.push_back({10'(x), 10'(y), 4'(ls), 4'(rs), 1'(go), 1'(sv)});
    name_q.push_back(nm);
  endtask

  task automatic check_reset_state(input string nm);
    tests_run++;
    if (ballX !== 10'd320 || ballY !== 10'd240 || leftScore !== 4'd0 ||
        rightScore !== 4'd0 || game_over !== 1'b0 || serving !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s: got x=%0d y=%0d ls=%0d rs=%0d go=%0d srv=%0d, want reset values",
               nm, ballX, ballY, leftScore, rightScore, game_over, serving);
    end
  endtask

  // scoreboard monitor: outputs are compared on the falling edge
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    string        nm;
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {ballX, ballY, leftScore, rightScore, game_over, serving};
      tests_run++;
      if (a !== e) begin
        tests_failed++;
        $display("FAIL %s: got x=%0d y=%0d ls=%0d rs=%0d go=%0d srv=%0d, want x=%0d y=%0d ls=%0d rs=%0d go=%0d srv=%0d",
                 nm, a[29:20], a[19:10], a[9:6], a[5:2], a[1], a[0],
                 e[29:20], e[19:10], e[9:6], e[5:2], e[1], e[0]);
      end
    end
  end

  // watchdog: the directed sequence must finish within a bounded number of cycles
  initial begin
    done = 1'b0;
    repeat (WATCHDOG_CYCLES) @(posedge clk);
    if (!done) begin
      tests_failed++;
      $display("FAIL watchdog: sequence did not finish within %0d cycles", WATCHDOG_CYCLES);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
    end
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    frame_tick   = 1'b0;
    start        = 1'b0;
    leftPaddleY  = 10'd1023;
    rightPaddleY = 10'd1023;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_state("reset_state_direct");
    expect_out("reset_state", 320, 240, 0, 0, 0, 0);
    cycle();
    tick();
    expect_out("idle_ignores_tick", 320, 240, 0, 0, 0, 0);

    // point 1: serve right/up, top bounce, right paddle edge hit, bottom bounce, left miss
    start = 1'b1; frame_tick = 1'b1;
    cycle();
    start = 1'b0; frame_tick = 1'b0;
    expect_out("start_enters_serve", 320, 240, 0, 0, 0, 1);
    ticks(59);
    expect_out("serve_59_holds", 320, 240, 0, 0, 0, 1);
    tick();
    expect_out("serve_60_play", 320, 240, 0, 0, 0, 0);
    tick();
    expect_out("first_move", 322, 238, 0, 0, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_out("start_ignored_play", 324, 236, 0, 0, 0, 0);
    ticks(116);
    expect_out("near_top_no_bounce", 556, 4, 0, 0, 0, 0);
    tick();
    expect_out("top_bounce", 558, 2, 0, 0, 0, 0);
    tick();
    expect_out("after_top_moves_down", 560, 4, 0, 0, 0, 0);
    ticks(25);
    rightPaddleY = 10'd96;
    tick();
    rightPaddleY = 10'd1023;
    expect_out("right_paddle_reach_edge", 611, 56, 0, 0, 0, 0);
    ticks(210);
    expect_out("near_bottom", 191, 476, 0, 0, 0, 0);
    tick();
    expect_out("bottom_bounce", 189, 477, 0, 0, 0, 0);
    ticks(93);
    expect_out("before_left_miss", 3, 291, 0, 0, 0, 0);
    tick();
    expect_out("scored_cycle", 3, 289, 0, 0, 0, 0);
    tick();
    expect_out("right_scores_serve", 320, 240, 0, 1, 0, 1);

    // point 2: serve left/down; the tick seen in SCORED must not count
    ticks(59);
    expect_out("scored_tick_not_counted", 320, 240, 0, 1, 0, 1);
    tick();
    expect_out("serve2_play", 320, 240, 0, 1, 0, 0);
    tick();
    expect_out("serve2_heads_left_down", 318, 242, 0, 1, 0, 0);
    ticks(144);
    leftPaddleY = 10'd382;
    tick();
    leftPaddleY = 10'd1023;
    expect_out("left_paddle_just_out_of_reach", 28, 423, 0, 1, 0, 0);
    ticks(12);
    tick();
    expect_out("left_miss_at_x4", 4, 397, 0, 1, 0, 0);
    cycle();
    expect_out("rscore_2", 320, 240, 0, 2, 0, 1);

    // point 3: serve left/up, left paddle edge hit, right miss
    ticks(60);
    ticks(145);
    leftPaddleY = 10'd96;
    tick();
    leftPaddleY = 10'd1023;
    expect_out("left_paddle_reach_edge", 29, 56, 0, 2, 0, 0);
    ticks(303);
    tick();
    expect_out("right_miss_at_x635", 635, 291, 0, 2, 0, 0);
    cycle();
    expect_out("left_scores_serve", 320, 240, 1, 2, 0, 1);

    // point 4: serve right/down, right paddle center hit, left miss
    ticks(60);
    ticks(145);
    rightPaddleY = 10'd425;
    tick();
    rightPaddleY = 10'd1023;
    expect_out("right_paddle_center_hit", 611, 423, 1, 2, 0, 0);
    ticks(304);
    tick();
    expect_out("left_miss_p4", 3, 190, 1, 2, 0, 0);
    cycle();
    expect_out("rscore_3", 320, 240, 1, 3, 0, 1);

    // points 5-8: straight left misses with alternating serve dy
    for (int p = 0; p < 4; p++) begin
      ticks(60);
      ticks(158);
      tick();
      expect_out("left_miss_loop", 4, (p % 2 == 0) ? 82 : 397, 1, 3 + p, 0, 0);
      cycle();
      if (p < 3) expect_out("loop_serve", 320, 240, 1, 4 + p, 0, 1);
      else       expect_out("game_over_entry", 320, 240, 1, 7, 1, 0);
    end
    ticks(5);
    expect_out("game_over_frozen", 320, 240, 1, 7, 1, 0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    expect_out("restart_clears_scores", 320, 240, 0, 0, 0, 1);

    // asynchronous reset in the middle of play, checked before the next clock edge
    ticks(60);
    ticks(3);
    #1;
    reset = 1'b1;
    #1;
    check_reset_state("async_reset_direct");
    expect_out("async_reset_mid_play", 320, 240, 0, 0, 0, 0);
    cycle();
    cycle();
    reset = 1'b0;
    tick();
    expect_out("idle_after_reset", 320, 240, 0, 0, 0, 0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    expect_out("start_after_reset", 320, 240, 0, 0, 0, 1);

    cycle();
    cycle();
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
